// File: rtl/ram_256to32_unpack_if.sv
// Stream bundle for the 256-to-32 unpacker: wide word input side plus
// narrow beat output side. The slave modport is the unpacker's view.
interface ram_256to32_unpack_if #(
    parameter int IN_WIDTH  = 256,
    parameter int OUT_WIDTH = 32
);
    localparam int CNT_WIDTH = $clog2(IN_WIDTH / OUT_WIDTH);

    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic [CNT_WIDTH-1:0] in_nbeats;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_word_last;
    logic                 out_last;
    logic                 busy;

    modport slave (
        input  in_valid, in_data, in_nbeats, in_last, out_ready,
        output in_ready, out_valid, out_data, out_word_last, out_last, busy
    );

    modport master (
        output in_valid, in_data, in_nbeats, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_word_last, out_last, busy
    );
endinterface

// File: rtl/ram_256to32_unpack.sv
// Width-down converter: holds one wide word and emits it as narrow beats,
// one per cycle, reloading on the word-last beat so back-to-back words
// stream without bubbles.
module ram_256to32_unpack #(
    parameter int IN_WIDTH  = 256,
    parameter int OUT_WIDTH = 32,
    parameter int LSB_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_256to32_unpack_if.slave   bus
);
    localparam int RATIO     = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_WIDTH = $clog2(RATIO);

    logic                 hold_valid_q,  hold_valid_d;
    logic [CNT_WIDTH-1:0] beat_cnt_q,    beat_cnt_d;
    logic [IN_WIDTH-1:0]  hold_data_q,   hold_data_d;
    logic [CNT_WIDTH-1:0] hold_nbeats_q, hold_nbeats_d;
    logic                 hold_last_q,   hold_last_d;

    logic                 word_last;
    logic                 in_ready;
    logic                 accept_in;
    logic                 out_fire;
    logic [OUT_WIDTH-1:0] slice [RATIO];

    // Beat k of the held word, ordered according to LSB_FIRST
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
        if (LSB_FIRST != 0) begin : g_lsb
            assign slice[gi] = hold_data_q[gi*OUT_WIDTH +: OUT_WIDTH];
        end else begin : g_msb
            assign slice[gi] = hold_data_q[IN_WIDTH-1-gi*OUT_WIDTH -: OUT_WIDTH];
        end
    end

    assign word_last = hold_valid_q && (beat_cnt_q == hold_nbeats_q);
    // Ready also on the final beat being taken, so the next word loads seamlessly
    assign in_ready  = !hold_valid_q || (bus.out_ready && word_last);
    assign accept_in = bus.in_valid && in_ready;
    assign out_fire  = hold_valid_q && bus.out_ready;

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = hold_valid_q;
    assign bus.busy          = hold_valid_q;
    assign bus.out_data      = slice[beat_cnt_q];
    assign bus.out_word_last = word_last;
    assign bus.out_last      = word_last && hold_last_q;

    // Next-state: advance beat, retire word, or load a new one (load wins)
    always_comb begin
        hold_valid_d  = hold_valid_q;
        beat_cnt_d    = beat_cnt_q;
        hold_data_d   = hold_data_q;
        hold_nbeats_d = hold_nbeats_q;
        hold_last_d   = hold_last_q;

        if (out_fire) begin
            if (word_last) begin
                hold_valid_d = 1'b0;
                beat_cnt_d   = '0;
            end else begin
                beat_cnt_d   = beat_cnt_q + CNT_WIDTH'(1);
            end
        end

        if (accept_in) begin
            hold_valid_d  = 1'b1;
            beat_cnt_d    = '0;
            hold_data_d   = bus.in_data;
            hold_nbeats_d = bus.in_nbeats;
            hold_last_d   = bus.in_last;
        end
    end

    // State registers; reset drops any held word immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q  <= 1'b0;
            beat_cnt_q    <= '0;
            hold_data_q   <= '0;
            hold_nbeats_q <= '0;
            hold_last_q   <= 1'b0;
        end else begin
            hold_valid_q  <= hold_valid_d;
            beat_cnt_q    <= beat_cnt_d;
            hold_data_q   <= hold_data_d;
            hold_nbeats_q <= hold_nbeats_d;
            hold_last_q   <= hold_last_d;
        end
    end
endmodule

// File: tb/tb_ram_256to32_unpack.sv
// Directed bench for the 256-to-32 unpacker. Two instances share stimulus:
// dut_a uses LSB-first ordering, dut_b MSB-first.
module tb_ram_256to32_unpack;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ram_256to32_unpack_if #(.IN_WIDTH(256), .OUT_WIDTH(32)) bus_a ();
    ram_256to32_unpack_if #(.IN_WIDTH(256), .OUT_WIDTH(32)) bus_b ();

    ram_256to32_unpack #(.IN_WIDTH(256), .OUT_WIDTH(32), .LSB_FIRST(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    ram_256to32_unpack #(.IN_WIDTH(256), .OUT_WIDTH(32), .LSB_FIRST(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word whose LSB-first beat k is base+k
    function automatic logic [255:0] mk_word(input logic [31:0] base);
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[32*k +: 32] = base + 32'(k);
        return w;
    endfunction

    task automatic drive_in(input logic v, input logic [255:0] d,
                            input logic [2:0] nb, input logic l);
        bus_a.in_valid = v; bus_a.in_data = d; bus_a.in_nbeats = nb; bus_a.in_last = l;
        bus_b.in_valid = v; bus_b.in_data = d; bus_b.in_nbeats = nb; bus_b.in_last = l;
    endtask

    task automatic set_ready(input logic r);
        bus_a.out_ready = r;
        bus_b.out_ready = r;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_in(1'b0, '0, 3'd0, 1'b0);
        set_ready(1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_checks++;
            if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1 || bus_a.busy !== 1'b0 ||
                bus_a.out_last !== 1'b0 || bus_a.out_word_last !== 1'b0 || bus_a.out_data !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d got v=%b rdy=%b busy=%b last=%b wl=%b d=%h exp v=0 rdy=1 busy=0 last=0 wl=0 d=0",
                         c, bus_a.out_valid, bus_a.in_ready, bus_a.busy, bus_a.out_last,
                         bus_a.out_word_last, bus_a.out_data);
            end
            @(negedge clk);
        end
        $display("reset: idle state checked");
    endtask

    task automatic test_full_word();
        logic [31:0] base;
        base = 32'hA5A5_0000;
        set_ready(1'b1);
        drive_in(1'b1, mk_word(base), 3'd7, 1'b0);
        @(negedge clk);
        drive_in(1'b0, '0, 3'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== base + 32'(k)) begin
                n_fail++;
                $display("FAIL full_a_data k=%0d got v=%b d=%h exp v=1 d=%h",
                         k, bus_a.out_valid, bus_a.out_data, base + 32'(k));
            end
            n_checks++;
            if (bus_a.out_word_last !== (k == 7) || bus_a.out_last !== 1'b0 ||
                bus_a.in_ready !== (k == 7)) begin
                n_fail++;
                $display("FAIL full_a_flags k=%0d got wl=%b last=%b rdy=%b exp wl=%b last=0 rdy=%b",
                         k, bus_a.out_word_last, bus_a.out_last, bus_a.in_ready, k == 7, k == 7);
            end
            n_checks++;
            if (bus_b.out_data !== base + 32'(7 - k)) begin
                n_fail++;
                $display("FAIL full_b_data k=%0d got %h exp %h", k, bus_b.out_data, base + 32'(7 - k));
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain got v=%b busy=%b exp 0 0", bus_a.out_valid, bus_a.busy);
        end
        $display("full_word: base %h, 8 beats", base);
    endtask

    task automatic test_back_to_back();
        int wi;
        int rdy_cnt;
        logic [31:0] exp;
        wi = 0;
        rdy_cnt = 0;
        set_ready(1'b1);
        @(negedge clk);
        drive_in(1'b1, mk_word(32'h0000_0000), 3'd7, 1'b0);
        @(negedge clk);
        wi = 1;
        drive_in(1'b1, mk_word(32'h0000_0100), 3'd7, 1'b0);
        for (int b = 0; b < 32; b++) begin
            #1;
            exp = (32'(b / 8) << 8) | 32'(b % 8);
            n_checks++;
            if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== exp) begin
                n_fail++;
                $display("FAIL b2b_data b=%0d got v=%b d=%h exp v=1 d=%h", b, bus_a.out_valid, bus_a.out_data, exp);
            end
            n_checks++;
            if (bus_a.in_ready !== ((b % 8) == 7)) begin
                n_fail++;
                $display("FAIL b2b_ready b=%0d got %b exp %b", b, bus_a.in_ready, (b % 8) == 7);
            end
            if (bus_a.in_ready === 1'b1) rdy_cnt++;
            @(negedge clk);
            if ((b % 8) == 7) begin
                wi++;
                if (wi < 4) drive_in(1'b1, mk_word(32'(wi) << 8), 3'd7, 1'b0);
                else        drive_in(1'b0, '0, 3'd0, 1'b0);
            end
        end
        #1;
        n_checks++;
        if (rdy_cnt != 4 || bus_a.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_summary got rdy_cnt=%0d v=%b exp rdy_cnt=4 v=0", rdy_cnt, bus_a.out_valid);
        end
        $display("back_to_back: 4 words, 32 beats");
    endtask

    task automatic test_backpressure();
        logic [31:0] base;
        logic [15:0] pat;
        int          exp;
        logic        r;
        base = 32'hB0B0_0000;
        pat  = 16'b1110_1101_0010_1001; // bit c = out_ready in cycle c
        exp  = 0;
        @(negedge clk);
        set_ready(1'b0);
        drive_in(1'b1, mk_word(base), 3'd7, 1'b0);
        @(negedge clk);
        drive_in(1'b0, '0, 3'd0, 1'b0);
        for (int c = 0; c < 40 && exp < 8; c++) begin
            r = (c < 16) ? pat[c] : 1'b1;
            set_ready(r);
            #1;
            n_checks++;
            if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== base + 32'(exp) ||
                bus_a.out_word_last !== (exp == 7)) begin
                n_fail++;
                $display("FAIL bp_beat c=%0d got v=%b d=%h wl=%b exp v=1 d=%h wl=%b",
                         c, bus_a.out_valid, bus_a.out_data, bus_a.out_word_last, base + 32'(exp), exp == 7);
            end
            n_checks++;
            if (bus_a.in_ready !== (r && exp == 7)) begin
                n_fail++;
                $display("FAIL bp_ready c=%0d got %b exp %b", c, bus_a.in_ready, r && exp == 7);
            end
            @(negedge clk);
            if (r) exp++;
        end
        #1;
        n_checks++;
        if (exp != 8 || bus_a.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_count got beats=%0d v=%b exp beats=8 v=0", exp, bus_a.out_valid);
        end
        set_ready(1'b1);
        $display("backpressure: %0d beats delivered", exp);
    endtask

    task automatic test_partial();
        logic [31:0] base;
        logic [31:0] base2;
        base  = 32'hC0C0_0000;
        base2 = 32'hD0D0_0000;
        set_ready(1'b1);
        @(negedge clk);
        drive_in(1'b1, mk_word(base), 3'd2, 1'b1);
        @(negedge clk);
        drive_in(1'b0, '0, 3'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) drive_in(1'b1, mk_word(base2), 3'd7, 1'b0);
            #1;
            n_checks++;
            if (bus_a.out_data !== base + 32'(k) || bus_a.out_word_last !== (k == 2) ||
                bus_a.out_last !== (k == 2)) begin
                n_fail++;
                $display("FAIL partial_beat k=%0d got d=%h wl=%b last=%b exp d=%h wl=%b last=%b",
                         k, bus_a.out_data, bus_a.out_word_last, bus_a.out_last,
                         base + 32'(k), k == 2, k == 2);
            end
            @(negedge clk);
        end
        drive_in(1'b0, '0, 3'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== base2 + 32'(k) || bus_a.out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL partial_next k=%0d got v=%b d=%h last=%b exp v=1 d=%h last=0",
                         k, bus_a.out_valid, bus_a.out_data, bus_a.out_last, base2 + 32'(k));
            end
            @(negedge clk);
        end
        $display("partial: 3-beat word then full word");
    endtask

    task automatic test_reset_mid();
        logic [31:0] base;
        base = 32'hE0E0_0000;
        set_ready(1'b1);
        @(negedge clk);
        drive_in(1'b1, mk_word(base), 3'd7, 1'b0);
        @(negedge clk);
        drive_in(1'b0, '0, 3'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (bus_a.out_data !== base + 32'(k)) begin
                n_fail++;
                $display("FAIL rstmid_pre k=%0d got %h exp %h", k, bus_a.out_data, base + 32'(k));
            end
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.in_ready !== 1'b1 ||
            bus_a.out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_async got v=%b busy=%b rdy=%b d=%h exp v=0 busy=0 rdy=1 d=0",
                     bus_a.out_valid, bus_a.busy, bus_a.in_ready, bus_a.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus_a.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_release got v=%b exp 0", bus_a.out_valid);
        end
        @(negedge clk);
        base = 32'hF0F0_0000;
        drive_in(1'b1, mk_word(base), 3'd7, 1'b0);
        @(negedge clk);
        drive_in(1'b0, '0, 3'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== base + 32'(k)) begin
                n_fail++;
                $display("FAIL rstmid_after k=%0d got v=%b d=%h exp v=1 d=%h",
                         k, bus_a.out_valid, bus_a.out_data, base + 32'(k));
            end
            @(negedge clk);
        end
        $display("reset_mid: word dropped, restart from beat 0");
    endtask

    task automatic test_msb_first();
        logic [255:0] w;
        w = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888,
             32'h9999_AAAA, 32'hBBBB_CCCC, 32'hDDDD_EEEE, 32'h0F0F_F0F0};
        set_ready(1'b1);
        @(negedge clk);
        drive_in(1'b1, w, 3'd7, 1'b1);
        @(negedge clk);
        drive_in(1'b0, '0, 3'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if (bus_b.out_data !== w[255-32*k -: 32] || bus_b.out_last !== (k == 7)) begin
                n_fail++;
                $display("FAIL msb_beat k=%0d got d=%h last=%b exp d=%h last=%b",
                         k, bus_b.out_data, bus_b.out_last, w[255-32*k -: 32], k == 7);
            end
            n_checks++;
            if (bus_a.out_data !== w[32*k +: 32]) begin
                n_fail++;
                $display("FAIL lsb_beat k=%0d got %h exp %h", k, bus_a.out_data, w[32*k +: 32]);
            end
            @(negedge clk);
        end
        $display("msb_first: 8 beats in both orders");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_full_word();
        test_back_to_back();
        test_backpressure();
        test_partial();
        test_reset_mid();
        test_msb_first();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got still running exp finished");
        $fatal(1, "timeout");
    end
endmodule
